// File: rtl/counter_cmd_ctrl.sv
// rtl/counter_cmd_ctrl.sv - button/switch conditioning and strobe generation for the saturating counter
// Optional auto-repeat of held direction buttons is enabled by defining CMD_AUTO_REPEAT_EN.
module counter_cmd_ctrl #(
    parameter int WIDTH      = 5,
    parameter int DB_CYCLES  = 4,
    parameter int REP_DELAY  = 16,
    parameter int REP_PERIOD = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             BTN_UP,
    input  logic             BTN_DOWN,
    input  logic             BTN_LOAD,
    input  logic [WIDTH-1:0] SW,
    input  logic             High,
    input  logic             Low,
    output logic             Up,
    output logic             Down,
    output logic             Load,
    output logic [WIDTH-1:0] IN
);

    localparam logic [7:0] CNT_LAST = 8'(DB_CYCLES - 1);

    // bit 0 = up, bit 1 = down, bit 2 = load
    logic [2:0]       btn_s1, btn_s2;
    logic [2:0]       db_lvl, db_prev;
    logic [7:0]       db_cnt [3];
    logic [WIDTH-1:0] sw_s1, sw_s2;
    logic [2:0]       press;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            btn_s1  <= '0;
            btn_s2  <= '0;
            sw_s1   <= '0;
            sw_s2   <= '0;
            db_lvl  <= '0;
            db_prev <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            btn_s1  <= {BTN_LOAD, BTN_DOWN, BTN_UP};
            btn_s2  <= btn_s1;
            sw_s1   <= SW;
            sw_s2   <= sw_s1;
            db_prev <= db_lvl;
            for (int i = 0; i < 3; i++) begin
                if (btn_s2[i] != db_lvl[i]) begin
                    if (db_cnt[i] == CNT_LAST) begin
                        db_lvl[i] <= btn_s2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 8'd1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign press = db_lvl & ~db_prev;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FIRST  = 3'd1,
`ifdef CMD_AUTO_REPEAT_EN
        S_WAIT   = 3'd2,
        S_REPEAT = 3'd3,
`else
        S_HOLD   = 3'd4,
`endif
        S_BLOCK  = 3'd5
    } state_t;

    state_t state, state_nxt;
    logic   dir, dir_nxt;       // 0 = up, 1 = down
    logic   dir_due, load_due, act_lvl;
    logic   up_nxt, down_nxt;

`ifdef CMD_AUTO_REPEAT_EN
    localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int TW      = (REP_MAX > 2) ? $clog2(REP_MAX) : 1;
    logic [TW-1:0] timer, timer_nxt;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
            dir   <= 1'b0;
            Up    <= 1'b0;
            Down  <= 1'b0;
            Load  <= 1'b0;
            IN    <= '0;
`ifdef CMD_AUTO_REPEAT_EN
            timer <= '0;
`endif
        end else begin
            state <= state_nxt;
            dir   <= dir_nxt;
            Up    <= up_nxt;
            Down  <= down_nxt;
            Load  <= load_due;
            if (load_due) IN <= sw_s2;
`ifdef CMD_AUTO_REPEAT_EN
            timer <= timer_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        dir_due   = 1'b0;
        act_lvl   = dir ? db_lvl[1] : db_lvl[0];
`ifdef CMD_AUTO_REPEAT_EN
        timer_nxt = timer;
`endif
        if (db_lvl[0] && db_lvl[1]) begin
            state_nxt = S_BLOCK;
        end else begin
            case (state)
                S_IDLE: begin
                    if (press[0] || press[1]) begin
                        state_nxt = S_FIRST;
                        dir_nxt   = press[1];
                        dir_due   = 1'b1;
                    end
                end
                S_FIRST: begin
                    if (!act_lvl) begin
                        state_nxt = S_IDLE;
                    end else begin
`ifdef CMD_AUTO_REPEAT_EN
                        // FIRST already consumed one cycle of the delay
                        state_nxt = S_WAIT;
                        timer_nxt = TW'(REP_DELAY - 2);
`else
                        state_nxt = S_HOLD;
`endif
                    end
                end
`ifdef CMD_AUTO_REPEAT_EN
                S_WAIT: begin
                    if (!act_lvl) begin
                        state_nxt = S_IDLE;
                    end else if (timer == '0) begin
                        dir_due = 1'b1;
                        if (load_due) begin
                            timer_nxt = TW'(REP_DELAY - 1);
                        end else begin
                            state_nxt = S_REPEAT;
                            timer_nxt = TW'(REP_PERIOD - 1);
                        end
                    end else begin
                        timer_nxt = timer - 1'b1;
                    end
                end
                S_REPEAT: begin
                    if (!act_lvl) begin
                        state_nxt = S_IDLE;
                    end else if (timer == '0) begin
                        dir_due   = 1'b1;
                        timer_nxt = TW'(REP_PERIOD - 1);
                    end else begin
                        timer_nxt = timer - 1'b1;
                    end
                end
`else
                S_HOLD: begin
                    if (!act_lvl) state_nxt = S_IDLE;
                end
`endif
                S_BLOCK: begin
                    if (db_lvl[1:0] == 2'b00) state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Load wins any collision; saturation only suppresses the pulse, never the FSM
    always_comb begin
        load_due = press[2];
        up_nxt   = dir_due && !dir_nxt && !High && !load_due;
        down_nxt = dir_due &&  dir_nxt && !Low  && !load_due;
    end

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// tb/tb_counter_cmd_ctrl.sv - scoreboard bench for counter_cmd_ctrl with a 5-bit saturating counter model
module tb_counter_cmd_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       BTN_UP = 1'b0, BTN_DOWN = 1'b0, BTN_LOAD = 1'b0;
    logic [4:0] SW = '0;
    logic       High, Low;
    logic       Up, Down, Load;
    logic [4:0] IN;

    counter_cmd_ctrl #(.WIDTH(5), .DB_CYCLES(4), .REP_DELAY(16), .REP_PERIOD(4)) dut (
        .CLK(CLK), .RST(RST), .BTN_UP(BTN_UP), .BTN_DOWN(BTN_DOWN), .BTN_LOAD(BTN_LOAD),
        .SW(SW), .High(High), .Low(Low), .Up(Up), .Down(Down), .Load(Load), .IN(IN)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [4:0] cnt;
    assign High = (cnt == 5'd31);
    assign Low  = (cnt == 5'd0);
    always @(posedge CLK or negedge RST) begin
        if (!RST)                      cnt <= '0;
        else if (Load)                 cnt <= IN;
        else if (Up && cnt != 5'd31)   cnt <= cnt + 5'd1;
        else if (Down && cnt != 5'd0)  cnt <= cnt - 5'd1;
    end

    typedef struct {
        int         kind;   // 0 up, 1 down, 2 load
        int         at;
        logic [4:0] val;
    } exp_t;
    exp_t sb[$];

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push(int kind, int at, logic [4:0] val);
        exp_t e;
        e.kind = kind;
        e.at   = at;
        e.val  = val;
        sb.push_back(e);
    endtask

    // Strobe train for a direction button held 40 cycles starting at t
    task automatic push_train(int kind, int t);
        push(kind, t + 7, 5'd0);
`ifdef CMD_AUTO_REPEAT_EN
        for (int c = t + 23; c <= t + 43; c += 4) push(kind, c, 5'd0);
`endif
    endtask

    task automatic step(int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_load(logic [4:0] v);
        SW = v;
        BTN_LOAD = 1'b1;
        push(2, cyc + 7, v);
        step(10);
        BTN_LOAD = 1'b0;
        step(10);
        chk("load_count", int'(cnt), int'(v));
    endtask

    always @(negedge CLK) begin
        while (sb.size() > 0 && sb[0].at < cyc) begin
            chk("missed_strobe_cycle", cyc, sb[0].at);
            void'(sb.pop_front());
        end
        if (RST && (Up || Down || Load)) begin
            int k;
            exp_t e;
            k = Load ? 2 : (Down ? 1 : 0);
            chk("strobe_onehot", int'($onehot({Up, Down, Load})), 1);
            if (sb.size() == 0) begin
                chk("unexpected_strobe_kind", k, -1);
            end else begin
                e = sb.pop_front();
                chk("strobe_kind", k, e.kind);
                chk("strobe_cycle", cyc, e.at);
                if (k == 2) chk("load_in_value", int'(IN), int'(e.val));
            end
        end
    end

    initial begin
        int t, u;

        step(3);
        chk("reset_up", int'(Up), 0);
        chk("reset_down", int'(Down), 0);
        chk("reset_load", int'(Load), 0);
        chk("reset_in", int'(IN), 0);
        RST = 1'b1;
        step(5);

        // bouncy load, then stable high
        SW = 5'b00101;
        for (int i = 0; i < 6; i++) begin
            BTN_LOAD = (i % 2 == 0);
            step(1);
        end
        BTN_LOAD = 1'b1;
        push(2, cyc + 7, 5'b00101);
        step(12);
        BTN_LOAD = 1'b0;
        step(10);
        chk("bouncy_in", int'(IN), 5);
        chk("bouncy_count", int'(cnt), 5);

        // held up from count 5
        BTN_UP = 1'b1;
        push_train(0, cyc);
        step(40);
        BTN_UP = 1'b0;
        step(12);
`ifdef CMD_AUTO_REPEAT_EN
        chk("held_up_count", int'(cnt), 12);
`else
        chk("held_up_count", int'(cnt), 6);
`endif

        // saturation at the top
        do_load(5'd29);
        t = cyc;
        BTN_UP = 1'b1;
        push(0, t + 7, 5'd0);
`ifdef CMD_AUTO_REPEAT_EN
        push(0, t + 23, 5'd0);
`endif
        step(40);
        BTN_UP = 1'b0;
        step(12);
`ifdef CMD_AUTO_REPEAT_EN
        chk("sat_high_count", int'(cnt), 31);
`else
        chk("sat_high_count", int'(cnt), 30);
`endif

        // saturation at the bottom
        do_load(5'd0);
        BTN_DOWN = 1'b1;
        step(40);
        BTN_DOWN = 1'b0;
        step(12);
        chk("sat_low_count", int'(cnt), 0);

        // both direction buttons together, then down alone
        do_load(5'd10);
        BTN_UP = 1'b1;
        BTN_DOWN = 1'b1;
        step(20);
        BTN_UP = 1'b0;
        BTN_DOWN = 1'b0;
        step(12);
        chk("block_count", int'(cnt), 10);
        BTN_DOWN = 1'b1;
        push(1, cyc + 7, 5'd0);
        step(8);
        BTN_DOWN = 1'b0;
        step(12);
        chk("down_after_block", int'(cnt), 9);

        // load press landing on a repeat slot
        t = cyc;
        BTN_UP = 1'b1;
        push(0, t + 7, 5'd0);
`ifdef CMD_AUTO_REPEAT_EN
        push(0, t + 23, 5'd0);
`endif
        push(2, t + 27, 5'd3);
`ifdef CMD_AUTO_REPEAT_EN
        for (int c = t + 31; c <= t + 43; c += 4) push(0, c, 5'd0);
`endif
        step(20);
        SW = 5'd3;
        BTN_LOAD = 1'b1;
        step(10);
        BTN_LOAD = 1'b0;
        step(10);
        BTN_UP = 1'b0;
        step(12);
        chk("priority_in", int'(IN), 3);
`ifdef CMD_AUTO_REPEAT_EN
        chk("priority_count", int'(cnt), 7);
`else
        chk("priority_count", int'(cnt), 3);
`endif

        // reset while the up button is held
        t = cyc;
        BTN_UP = 1'b1;
        push(0, t + 7, 5'd0);
`ifdef CMD_AUTO_REPEAT_EN
        push(0, t + 23, 5'd0);
        push(0, t + 27, 5'd0);
`endif
        step(27);
        #2 RST = 1'b0;
        #1;
        chk("midreset_up", int'(Up), 0);
        chk("midreset_down", int'(Down), 0);
        chk("midreset_load", int'(Load), 0);
        chk("midreset_in", int'(IN), 0);
        step(3);
        RST = 1'b1;
        u = cyc;
        push(0, u + 7, 5'd0);
        step(10);
        BTN_UP = 1'b0;
        step(12);
        chk("after_reset_count", int'(cnt), 1);

        // held down from count 10
        do_load(5'd10);
        BTN_DOWN = 1'b1;
        push_train(1, cyc);
        step(40);
        BTN_DOWN = 1'b0;
        step(12);
`ifdef CMD_AUTO_REPEAT_EN
        chk("held_down_count", int'(cnt), 3);
`else
        chk("held_down_count", int'(cnt), 9);
`endif

        step(5);
        chk("scoreboard_leftover", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
